// File: rtl/vae_layer_sequencer.sv
// -----------------------------------------------------------------------------
// vae_layer_sequencer
//
// Walks a chain of NUM_LAYERS nnsingle-array layers through one decode pass.
// Each layer is enabled (RUN) until it raises its finish bit. Its outputs are
// then latched by a one-cycle capture strobe (CAPTURE). A one-cycle GAP with
// the enable low lets the layer clear its accumulators. After the last layer,
// a one-cycle DONE pulse reports the number of busy cycles in the pass.
//
// Optional feature (macro VAE_SEQ_TIMEOUT_EN):
//   When defined, a layer that stays in RUN for TIMEOUT_CYCLES cycles without
//   finishing sends the sequencer to ERR and raises the sticky error flag.
//   When undefined, there is no timeout counter, error is held at 0, and RUN
//   waits indefinitely.
//
// Ports:
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         request one full pass (only sampled in IDLE)
//   abort         abandon the current pass (RUN/CAPTURE/GAP)
//   layer_finish  finish_signal from each layer, bit i = layer i
//   layer_enable  level enable to each layer, at most one bit high
//   capture       one-cycle strobe to latch layer i outputs
//   layer_idx     index of the layer being run or captured
//   busy          high in RUN, CAPTURE and GAP
//   done          one-cycle pulse at pass completion
//   error         sticky timeout flag (0 unless VAE_SEQ_TIMEOUT_EN)
//   pass_cycles   busy cycles of the last completed pass, saturating
//
// All outputs come straight from flops, so no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module vae_layer_sequencer #(
  parameter int NUM_LAYERS     = 3,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int IDXW           = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_finish,
  output logic [NUM_LAYERS-1:0] layer_enable,
  output logic [NUM_LAYERS-1:0] capture,
  output logic [IDXW-1:0]       layer_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           pass_cycles
);

  // Elaboration-time parameter range checks.
  if (NUM_LAYERS < 1 || NUM_LAYERS > 8) begin : g_bad_num_layers
    $error("NUM_LAYERS must be in 1..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end
  if (IDXW < 1 || IDXW < $clog2(NUM_LAYERS)) begin : g_bad_idxw
    $error("IDXW must be at least max(1, clog2(NUM_LAYERS))");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_CAPTURE,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic [15:0] cycle_cnt;   // busy cycles of the pass in progress
  logic [15:0] cycle_inc;   // saturating cycle_cnt + 1
  logic        last_layer;

`ifdef VAE_SEQ_TIMEOUT_EN
  logic [15:0] run_cnt;     // completed RUN cycles of the current layer
`endif

  function automatic logic [NUM_LAYERS-1:0] onehot(input logic [IDXW-1:0] idx);
    return NUM_LAYERS'(1) << idx;
  endfunction

  // NOTE: every variable written in always_comb gets a value on every path
  // (here the single assignments are unconditional), otherwise a latch is
  // inferred.
  always_comb begin
    cycle_inc  = (cycle_cnt == 16'hFFFF) ? cycle_cnt : cycle_cnt + 16'd1;
    last_layer = (layer_idx == IDXW'(NUM_LAYERS - 1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      layer_enable <= '0;
      capture      <= '0;
      layer_idx    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      pass_cycles  <= '0;
      cycle_cnt    <= '0;
`ifdef VAE_SEQ_TIMEOUT_EN
      run_cnt      <= '0;
`endif
    end else begin
      // Strobes are high for exactly one cycle.
      capture <= '0;
      done    <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_RUN;
            layer_idx    <= '0;
            layer_enable <= onehot('0);
            busy         <= 1'b1;
            error        <= 1'b0;
            cycle_cnt    <= '0;
`ifdef VAE_SEQ_TIMEOUT_EN
            run_cnt      <= '0;
`endif
          end
        end

        S_RUN: begin
          cycle_cnt <= cycle_inc;
`ifdef VAE_SEQ_TIMEOUT_EN
          run_cnt   <= run_cnt + 16'd1;
`endif
          // Abort outranks finish; only the running layer's finish counts.
          if (abort) begin
            state        <= S_IDLE;
            layer_enable <= '0;
            layer_idx    <= '0;
            busy         <= 1'b0;
          end else if (layer_finish[layer_idx]) begin
            state        <= S_CAPTURE;
            layer_enable <= '0;
            capture      <= onehot(layer_idx);
          end
`ifdef VAE_SEQ_TIMEOUT_EN
          else if (run_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            state        <= S_ERR;
            layer_enable <= '0;
            busy         <= 1'b0;
            error        <= 1'b1;
          end
`endif
        end

        S_CAPTURE: begin
          cycle_cnt <= cycle_inc;
          if (abort) begin
            state     <= S_IDLE;
            layer_idx <= '0;
            busy      <= 1'b0;
          end else begin
            state <= S_GAP;
          end
        end

        S_GAP: begin
          cycle_cnt <= cycle_inc;
          if (abort) begin
            state     <= S_IDLE;
            layer_idx <= '0;
            busy      <= 1'b0;
          end else if (last_layer) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            // Include this GAP cycle, which cycle_cnt has not counted yet.
            pass_cycles <= cycle_inc;
          end else begin
            state        <= S_RUN;
            layer_idx    <= layer_idx + 1'b1;
            layer_enable <= onehot(layer_idx + 1'b1);
`ifdef VAE_SEQ_TIMEOUT_EN
            run_cnt      <= '0;
`endif
          end
        end

        S_DONE:  state <= S_IDLE;

        S_ERR:   state <= S_IDLE;   // error stays set until the next start

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vae_layer_sequencer.md
VAE_LAYER_SEQUENCER -- requirements
Module: vae_layer_sequencer

Interface
REQ-001 Parameter NUM_LAYERS, default 3: number of chained nnsingle-array layers sequenced, range 1..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 1023: maximum RUN cycles per layer before error, range 1..65535.
REQ-003 Parameter IDXW, default 2: layer index width, SHALL be at least clog2(NUM_LAYERS), minimum 1.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  request one full decode pass; sampled only in IDLE.
REQ-007 abort  input  1  synchronous abandon of the current pass.
REQ-008 layer_finish  input  NUM_LAYERS  finish_signal of each layer, bit i = layer i.
REQ-009 layer_enable  output  NUM_LAYERS  level enable to each layer's nnsingle array, at most one bit high.
REQ-010 capture  output  NUM_LAYERS  one-cycle strobe to latch layer i activate_node outputs.
REQ-011 layer_idx  output  IDXW  index of the layer being run or captured.
REQ-012 busy  output  1  high in RUN, CAPTURE, GAP.
REQ-013 done  output  1  one-cycle pulse at pass completion.
REQ-014 error  output  1  sticky timeout flag.
REQ-015 pass_cycles  output  16  busy-cycle count of the last completed pass, saturating at 65535.

Function
REQ-016 All outputs SHALL be registered; no combinational path from input to output.
REQ-017 States: IDLE, RUN, CAPTURE, GAP, DONE, ERR.
REQ-018 IDLE: start=1 -> RUN with layer_idx=0, error cleared, internal cycle counter cleared.
REQ-019 RUN: layer_enable[layer_idx]=1, all other bits 0; layer_finish[layer_idx]=1 -> CAPTURE; finish bits of other layers ignored.
REQ-020 CAPTURE (1 cycle): layer_enable all 0, capture[layer_idx]=1 -> GAP.
REQ-021 GAP (1 cycle, enable low so the layer clears its accumulators): if layer_idx=NUM_LAYERS-1 -> DONE, else layer_idx+1 -> RUN.
REQ-022 DONE (1 cycle): done=1, pass_cycles updated, busy=0 -> IDLE.
REQ-023 Per-layer cost is N+2 cycles, where N is the RUN cycle in which finish is sampled high.
REQ-024 start while busy, in DONE, or in ERR SHALL be ignored; no queuing.
REQ-025 abort=1 in RUN, CAPTURE, or GAP -> IDLE next cycle, all enables and strobes 0, no done, pass_cycles unchanged; abort has priority over finish in the same cycle.
REQ-026 Internal counter increments every busy cycle and saturates at 65535.
REQ-027 A finish stuck high on entering RUN SHALL still be honoured, giving a minimum 1-cycle RUN.

Reset
REQ-028 rst_n low SHALL immediately force IDLE: layer_enable=0, capture=0, layer_idx=0, busy=0, done=0, error=0, pass_cycles=0, including mid-pass.
REQ-029 Release of reset takes effect on the first rising clk edge with rst_n high.

Configuration
REQ-030 Macro VAE_SEQ_TIMEOUT_EN defined: a per-layer RUN counter reaching TIMEOUT_CYCLES without finish -> ERR.
REQ-031 In ERR, enables are 0 and error=1; error stays high until the next accepted start; ERR -> IDLE in 1 cycle.
REQ-032 Macro VAE_SEQ_TIMEOUT_EN undefined: no timeout counter, error tied 0, RUN waits indefinitely.

Verification
REQ-033 NUM_LAYERS=3; start at cycle 0; each layer finishes in RUN cycle 6 -> enable[0] cycles 1-6, capture[0] at 7, enable[1] from 9, done at 25, pass_cycles=24.
REQ-034 Start pulsed again at cycle 10 of a pass -> ignored; exactly one done pulse.
REQ-035 Abort and finish both high in layer1 RUN -> IDLE next cycle, no capture[1], no done, pass_cycles keeps its prior value.
REQ-036 With VAE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, layer0 never finishes -> ERR after 8 RUN cycles, error=1; next start clears error.
REQ-037 rst_n pulled low during layer2 RUN -> all outputs 0 asynchronously; a new pass after release completes normally.
REQ-038 layer_finish[2] held high throughout with layer 0 running -> ignored until layer 2 runs, then RUN lasts 1 cycle.
